// File: rtl/pwconv_pkg.sv
// Shared types and arithmetic helpers for the depthwise-separable conv stages.
// sat8 and rshift_round are also used by the depthwise stage.
package pwconv_pkg;

  localparam int ACC_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic signed [7:0] sat8(input logic signed [ACC_W-1:0] v);
    if (v > 127)
      return 8'sd127;
    else if (v < -128)
      return 8'sh80;
    else
      return v[7:0];
  endfunction

  // Add half an LSB, then arithmetic shift: round-half-up on the kept LSB.
  function automatic logic signed [ACC_W-1:0] rshift_round(input logic signed [ACC_W-1:0] v,
                                                          input int shift);
    if (shift <= 0)
      return v;
    return (v + ($signed(ACC_W'(1)) <<< (shift - 1))) >>> shift;
  endfunction

  function automatic logic signed [7:0] w_init(input int co, input int ci);
    return (co == ci) ? 8'sd127 : 8'(ci - co);
  endfunction

  function automatic logic signed [ACC_W-1:0] b_init(input int co, input int shift);
    if (shift <= 0)
      return ACC_W'(co);
    return ACC_W'(co) <<< shift;
  endfunction

endpackage

// File: rtl/pw_requant.sv
// Requantisation of a 32-bit accumulator value to int8: round, shift, saturate.
module pw_requant
  import pwconv_pkg::*;
#(
  parameter int SHIFT = 7
) (
  input  logic signed [ACC_W-1:0] v,
  output logic signed [7:0]       r
);

  assign r = sat8(rshift_round(v, SHIFT));

endmodule

// File: rtl/pwconv1d_int8.sv
// Pointwise 1x1 INT8 convolution: one MAC per cycle over a snapshotted input.
//
// state   | meaning
// --------+--------------------------------------------------
// ST_IDLE | waiting for start; z holds last job's results
// ST_RUN  | stepping ci (inner), t, co (outer); one MAC/cycle
module pwconv1d_int8
  import pwconv_pkg::*;
#(
  parameter int CIN   = 4,
  parameter int COUT  = 4,
  parameter int L     = 14,
  parameter int SHIFT = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic signed [7:0] x [CIN][L],
  output logic              busy,
  output logic              done,
  output logic signed [7:0] z [COUT][L]
);

  localparam int CI_W = (CIN > 1) ? $clog2(CIN) : 1;
  localparam int CO_W = (COUT > 1) ? $clog2(COUT) : 1;
  localparam int T_W  = (L > 1) ? $clog2(L) : 1;

  state_t state, state_nxt;

  logic signed [7:0]       xb [CIN][L];
  logic [CI_W-1:0]         ci;
  logic [CO_W-1:0]         co;
  logic [T_W-1:0]          t;
  logic signed [ACC_W-1:0] acc;
  logic                    done_q;

  logic                    ci_last, t_last, co_last, job_last;
  logic signed [7:0]       x_cur, w_cur;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] v;
  logic signed [7:0]       r;

  assign ci_last  = (ci == CI_W'(CIN - 1));
  assign t_last   = (t == T_W'(L - 1));
  assign co_last  = (co == CO_W'(COUT - 1));
  assign job_last = ci_last && t_last && co_last;

  always_comb begin
    x_cur = xb[ci][t];
    w_cur = w_init(int'(co), int'(ci));
    prod  = x_cur * w_cur;
    v     = acc + ACC_W'(prod) + b_init(int'(co), SHIFT);
  end

  pw_requant #(.SHIFT(SHIFT)) u_requant (
    .v(v),
    .r(r)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)    state_nxt = ST_RUN;
      ST_RUN:  if (job_last) state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
    done = done_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ci     <= '0;
      co     <= '0;
      t      <= '0;
      acc    <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < CIN; i++)
        for (int j = 0; j < L; j++)
          xb[i][j] <= '0;
      for (int i = 0; i < COUT; i++)
        for (int j = 0; j < L; j++)
          z[i][j] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            xb  <= x;
            ci  <= '0;
            co  <= '0;
            t   <= '0;
            acc <= '0;
          end
        end
        ST_RUN: begin
          if (ci_last) begin
            z[co][t] <= r;
            acc      <= '0;
            ci       <= '0;
            if (t_last) begin
              t  <= '0;
              co <= co_last ? '0 : co + 1'b1;
            end else begin
              t <= t + 1'b1;
            end
            done_q <= co_last && t_last;
          end else begin
            acc <= acc + ACC_W'(prod);
            ci  <= ci + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
